// File: rtl/parser_pkg.sv
// Shared constants, opcode encodings and state types for the host packet parser.
package parser_pkg;

  // Header opcode byte values
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  // Header is opcode, reserved, len_lsb, len_msb
  localparam int HDR_BYTES = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_MUL = 2'd1,
    ALU_DIV = 2'd2
  } alu_op_e;

  typedef enum logic [2:0] {
    S_OPCODE  = 3'd0,
    S_RSVD    = 3'd1,
    S_LEN_LSB = 3'd2,
    S_LEN_MSB = 3'd3,
    S_ECHO    = 3'd4,
    S_ALU     = 3'd5,
    S_DRAIN   = 3'd6
  } parser_state_e;

  // True for opcodes that feed the ALU operand path
  function automatic logic is_alu_opcode(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Map an ALU opcode byte to the ALU operation code
  function automatic alu_op_e alu_op_of(input logic [7:0] op);
    alu_op_e res;
    case (op)
      OP_ADD:  res = ALU_ADD;
      OP_MUL:  res = ALU_MUL;
      OP_DIV:  res = ALU_DIV;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles accepted payload bytes into little-endian 32-bit operand words and
// presents them on a valid/ready interface with first/last markers.
module word_packer
  import parser_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,        // start of a new ALU packet
  input  logic [13:0] num_words_i,   // operand words in the packet
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,  // byte accepted this cycle
  input  logic        word_ready_i,
  output logic [31:0] word_data_o,
  output logic        word_first_o,
  output logic        word_last_o,
  output logic        word_valid_o
);

  logic [23:0] shift_r;        // bytes 0..2 of the word in progress, byte0 at [7:0]
  logic [1:0]  byte_cnt_r;
  logic [13:0] words_left_r;
  logic        first_pending_r;
  logic [31:0] word_data_r;
  logic        word_first_r;
  logic        word_last_r;
  logic        word_valid_r;

  // Byte assembly, word counting and output handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_r         <= 24'h00_0000;
      byte_cnt_r      <= 2'd0;
      words_left_r    <= 14'd0;
      first_pending_r <= 1'b0;
      word_data_r     <= 32'h0000_0000;
      word_first_r    <= 1'b0;
      word_last_r     <= 1'b0;
      word_valid_r    <= 1'b0;
    end else begin
      if (word_valid_r && word_ready_i) begin
        word_valid_r <= 1'b0;
      end
      if (load_i) begin
        byte_cnt_r      <= 2'd0;
        words_left_r    <= num_words_i;
        first_pending_r <= 1'b1;
      end else if (byte_valid_i) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        if (byte_cnt_r == 2'd3) begin
          // Upstream only accepts a byte when the output slot is free or freeing
          word_data_r     <= {byte_i, shift_r};
          word_valid_r    <= 1'b1;
          word_first_r    <= first_pending_r;
          word_last_r     <= (words_left_r == 14'd1);
          words_left_r    <= words_left_r - 14'd1;
          first_pending_r <= 1'b0;
        end else begin
          shift_r <= {byte_i, shift_r[23:8]};
        end
      end
    end
  end

  assign word_data_o  = word_data_r;
  assign word_first_o = word_first_r;
  assign word_last_o  = word_last_r;
  assign word_valid_o = word_valid_r;

endmodule

// File: rtl/packet_parser.sv
// Host-side packet parser: decodes {opcode, reserved, len_lsb, len_msb} headers,
// forwards ECHO payloads byte-wise, packs ALU payloads into operand words and
// drains malformed packets while pulsing err_o.
module packet_parser
  import parser_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 32'h0000_FFFF,
  parameter int unsigned MIN_OPERANDS = 32'd2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  echo_data_o,
  output logic        echo_valid_o,
  input  logic        echo_ready_i,
  output logic [15:0] echo_len_o,
  output logic [31:0] word_data_o,
  output logic [1:0]  word_op_o,
  output logic        word_first_o,
  output logic        word_last_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        err_o
);

  parser_state_e state_r;
  logic [7:0]    opcode_r;
  logic [7:0]    len_lsb_r;
  logic [15:0]   remaining_r;
  logic [7:0]    echo_data_r;
  logic          echo_valid_r;
  logic [15:0]   echo_len_r;
  alu_op_e       word_op_r;
  logic          err_r;

  logic          word_valid_s;
  logic          rx_ready_s;
  logic          rx_accept_s;
  logic          echo_free_s;
  logic          word_free_s;
  logic [15:0]   len_s;
  logic          is_echo_s;
  logic          is_alu_s;
  logic          len_too_big_s;
  logic          alu_len_bad_s;
  parser_state_e disp_state_s;
  logic          disp_err_s;
  logic          disp_echo_s;
  logic          disp_alu_s;
  logic          pack_load_s;
  logic          pack_byte_s;

  assign echo_free_s   = !echo_valid_r || echo_ready_i;
  assign word_free_s   = !word_valid_s || word_ready_i;
  assign rx_accept_s   = rx_valid_i && rx_ready_s;
  assign len_s         = {rx_data_i, len_lsb_r};
  assign is_echo_s     = (opcode_r == OP_ECHO);
  assign is_alu_s      = is_alu_opcode(opcode_r);
  assign len_too_big_s = (32'(len_s) > MAX_LEN);
  assign alu_len_bad_s = (len_s[1:0] != 2'b00) || (32'(len_s) < (32'd4 * MIN_OPERANDS));

  // Byte acceptance: header bytes wait for any pending output to free so that
  // echo_len_o/word_op_o never change under an unconsumed result
  always_comb begin
    rx_ready_s = 1'b0;
    if (rst_i) begin
      rx_ready_s = 1'b0;
    end else begin
      case (state_r)
        S_OPCODE, S_RSVD, S_LEN_LSB, S_LEN_MSB: rx_ready_s = echo_free_s && word_free_s;
        S_ECHO:  rx_ready_s = echo_free_s;
        S_ALU:   rx_ready_s = word_free_s;
        S_DRAIN: rx_ready_s = 1'b1;
        default: rx_ready_s = 1'b0;
      endcase
    end
  end

  // Dispatch decision taken when the length MSB is accepted
  always_comb begin
    disp_state_s = S_OPCODE;
    disp_err_s   = 1'b0;
    disp_echo_s  = 1'b0;
    disp_alu_s   = 1'b0;
    if (!is_echo_s && !is_alu_s) begin
      disp_err_s = 1'b1;
      if (len_s == 16'd0) begin
        disp_state_s = S_OPCODE;
      end else begin
        disp_state_s = S_DRAIN;
      end
    end else if (len_s == 16'd0) begin
      // Empty echo is silently complete; an ALU packet without operands is an error
      if (is_alu_s) begin
        disp_err_s = 1'b1;
      end else begin
        disp_echo_s = 1'b1;
      end
    end else if (len_too_big_s || (is_alu_s && alu_len_bad_s)) begin
      disp_err_s   = 1'b1;
      disp_state_s = S_DRAIN;
    end else if (is_alu_s) begin
      disp_alu_s   = 1'b1;
      disp_state_s = S_ALU;
    end else begin
      disp_echo_s  = 1'b1;
      disp_state_s = S_ECHO;
    end
  end

  // Main FSM: header decode, payload counting, echo register and error pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= S_OPCODE;
      opcode_r     <= 8'h00;
      len_lsb_r    <= 8'h00;
      remaining_r  <= 16'd0;
      echo_data_r  <= 8'h00;
      echo_valid_r <= 1'b0;
      echo_len_r   <= 16'd0;
      word_op_r    <= ALU_ADD;
      err_r        <= 1'b0;
    end else begin
      err_r <= 1'b0;
      if (echo_valid_r && echo_ready_i) begin
        echo_valid_r <= 1'b0;
      end
      case (state_r)
        S_OPCODE: begin
          if (rx_accept_s) begin
            opcode_r <= rx_data_i;
            state_r  <= S_RSVD;
          end
        end
        S_RSVD: begin
          if (rx_accept_s) begin
            state_r <= S_LEN_LSB;
          end
        end
        S_LEN_LSB: begin
          if (rx_accept_s) begin
            len_lsb_r <= rx_data_i;
            state_r   <= S_LEN_MSB;
          end
        end
        S_LEN_MSB: begin
          if (rx_accept_s) begin
            state_r     <= disp_state_s;
            err_r       <= disp_err_s;
            remaining_r <= len_s;
            if (disp_echo_s) begin
              echo_len_r <= len_s;
            end
            if (disp_alu_s) begin
              word_op_r <= alu_op_of(opcode_r);
            end
          end
        end
        S_ECHO: begin
          if (rx_accept_s) begin
            echo_data_r  <= rx_data_i;
            echo_valid_r <= 1'b1;
            remaining_r  <= remaining_r - 16'd1;
            if (remaining_r == 16'd1) begin
              state_r <= S_OPCODE;
            end
          end
        end
        S_ALU, S_DRAIN: begin
          if (rx_accept_s) begin
            remaining_r <= remaining_r - 16'd1;
            if (remaining_r == 16'd1) begin
              state_r <= S_OPCODE;
            end
          end
        end
        default: begin
          state_r <= S_OPCODE;
        end
      endcase
    end
  end

  assign pack_load_s = rx_accept_s && (state_r == S_LEN_MSB) && disp_alu_s;
  assign pack_byte_s = rx_accept_s && (state_r == S_ALU);

  word_packer u_word_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (pack_load_s),
    .num_words_i  (len_s[15:2]),
    .byte_i       (rx_data_i),
    .byte_valid_i (pack_byte_s),
    .word_ready_i (word_ready_i),
    .word_data_o  (word_data_o),
    .word_first_o (word_first_o),
    .word_last_o  (word_last_o),
    .word_valid_o (word_valid_s)
  );

  assign rx_ready_o   = rx_ready_s;
  assign echo_data_o  = echo_data_r;
  assign echo_valid_o = echo_valid_r;
  assign echo_len_o   = echo_len_r;
  assign word_op_o    = word_op_r;
  assign word_valid_o = word_valid_s;
  assign err_o        = err_r;

endmodule

// File: tb/tb_packet_parser.sv
// Directed self-checking bench for packet_parser.
module tb_packet_parser;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  echo_data_o;
  logic        echo_valid_o;
  logic        echo_ready_i;
  logic [15:0] echo_len_o;
  logic [31:0] word_data_o;
  logic [1:0]  word_op_o;
  logic        word_first_o;
  logic        word_last_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        err_o;

  int vec_cnt = 0;
  int miscompares = 0;
  int err_cnt = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  echo_q[$];
  logic [31:0] word_q[$];
  logic [3:0]  flag_q[$];   // {op, first, last}

  always #5 clk = ~clk;

  packet_parser dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .echo_data_o  (echo_data_o),
    .echo_valid_o (echo_valid_o),
    .echo_ready_i (echo_ready_i),
    .echo_len_o   (echo_len_o),
    .word_data_o  (word_data_o),
    .word_op_o    (word_op_o),
    .word_first_o (word_first_o),
    .word_last_o  (word_last_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .err_o        (err_o)
  );

  // Record output transfers and error pulses midway between active edges
  always @(negedge clk) begin
    if (!rst_i) begin
      if (echo_valid_o && echo_ready_i) echo_q.push_back(echo_data_o);
      if (word_valid_o && word_ready_i) begin
        word_q.push_back(word_data_o);
        flag_q.push_back({word_op_o, word_first_o, word_last_o});
      end
      if (err_o) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one byte (caller is just after a posedge); returns just after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    n = 0;
    @(negedge clk);
    while (!rx_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("rx_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_q();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    echo_q.delete();
    word_q.delete();
    flag_q.delete();
    err_cnt = 0;
  endtask

  function automatic logic [31:0] echo_at(input int i);
    return (echo_q.size() > i) ? {24'h0, echo_q[i]} : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] word_at(input int i);
    return (word_q.size() > i) ? word_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] flag_at(input int i);
    return (flag_q.size() > i) ? {28'h0, flag_q[i]} : 32'hDEAD_BEEF;
  endfunction

  initial begin
    rst_i        = 1'b1;
    rx_valid_i   = 1'b0;
    rx_data_i    = 8'h00;
    echo_ready_i = 1'b1;
    word_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Reset state
    check("rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
    check("rst_echo_valid", {31'd0, echo_valid_o}, 32'd0);
    check("rst_word_valid", {31'd0, word_valid_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_echo_len", {16'd0, echo_len_o}, 32'd0);
    check("rst_word_data", word_data_o, 32'd0);

    // 1: echo len 2
    clear_obs();
    tx_q = {8'hEC, 8'h00, 8'h02, 8'h00, 8'h5A, 8'hC3};
    send_q();
    idle(4);
    check("t1_echo_cnt", echo_q.size(), 32'd2);
    check("t1_echo0", echo_at(0), 32'h5A);
    check("t1_echo1", echo_at(1), 32'hC3);
    check("t1_echo_len", {16'd0, echo_len_o}, 32'd2);
    check("t1_err", err_cnt, 32'd0);

    // 2: ADD len 8
    clear_obs();
    tx_q = {8'hA0, 8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_q();
    idle(4);
    check("t2_word_cnt", word_q.size(), 32'd2);
    check("t2_word0", word_at(0), 32'h0000_0001);
    check("t2_flag0", flag_at(0), 32'b0010);
    check("t2_word1", word_at(1), 32'h0000_0002);
    check("t2_flag1", flag_at(1), 32'b0001);
    check("t2_err", err_cnt, 32'd0);

    // 3: ADD len 8 with word_ready low for 20+ cycles
    clear_obs();
    word_ready_i = 1'b0;
    tx_q = {8'hA0, 8'h00, 8'h08, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    fork
      send_q();
      begin
        repeat (12) @(negedge clk);
        check("t3_hold_valid_a", {31'd0, word_valid_o}, 32'd1);
        check("t3_hold_data_a", word_data_o, 32'h1122_3344);
        check("t3_rx_blocked_a", {31'd0, rx_ready_o}, 32'd0);
        repeat (20) @(negedge clk);
        check("t3_hold_valid_b", {31'd0, word_valid_o}, 32'd1);
        check("t3_hold_data_b", word_data_o, 32'h1122_3344);
        check("t3_rx_blocked_b", {31'd0, rx_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        word_ready_i = 1'b1;
      end
    join
    idle(4);
    check("t3_word_cnt", word_q.size(), 32'd2);
    check("t3_word0", word_at(0), 32'h1122_3344);
    check("t3_flag0", flag_at(0), 32'b0010);
    check("t3_word1", word_at(1), 32'h5566_7788);
    check("t3_flag1", flag_at(1), 32'b0001);

    // 4: unknown opcode drained, then a good echo
    clear_obs();
    tx_q = {8'h55, 8'h00, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    send_q();
    idle(3);
    check("t4_err_cnt", err_cnt, 32'd1);
    check("t4_no_echo", echo_q.size(), 32'd0);
    check("t4_no_word", word_q.size(), 32'd0);
    tx_q = {8'hEC, 8'h00, 8'h01, 8'h00, 8'h77};
    send_q();
    idle(3);
    check("t4_echo_cnt", echo_q.size(), 32'd1);
    check("t4_echo0", echo_at(0), 32'h77);
    check("t4_echo_len", {16'd0, echo_len_o}, 32'd1);
    check("t4_err_after", err_cnt, 32'd1);

    // 5: MUL len 6 (not a multiple of 4), DIV len 0
    clear_obs();
    tx_q = {8'hA1, 8'h00, 8'h06, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_q();
    idle(3);
    check("t5_mul_err", err_cnt, 32'd1);
    tx_q = {8'hA2, 8'h00, 8'h00, 8'h00};
    send_q();
    idle(3);
    check("t5_div_err", err_cnt, 32'd2);
    check("t5_no_word", word_q.size(), 32'd0);
    tx_q = {8'hEC, 8'h00, 8'h01, 8'h00, 8'h33};
    send_q();
    idle(3);
    check("t5_echo0", echo_at(0), 32'h33);
    check("t5_err_final", err_cnt, 32'd2);

    // 7: echo backpressure holds data and stalls rx
    clear_obs();
    echo_ready_i = 1'b0;
    tx_q = {8'hEC, 8'h00, 8'h03, 8'h00, 8'h10, 8'h20, 8'h30};
    fork
      send_q();
      begin
        repeat (8) @(negedge clk);
        check("t7_hold_valid", {31'd0, echo_valid_o}, 32'd1);
        check("t7_hold_data", {24'd0, echo_data_o}, 32'h10);
        check("t7_rx_blocked", {31'd0, rx_ready_o}, 32'd0);
        check("t7_echo_len", {16'd0, echo_len_o}, 32'd3);
        @(posedge clk);
        #1;
        echo_ready_i = 1'b1;
      end
    join
    idle(4);
    check("t7_echo_cnt", echo_q.size(), 32'd3);
    check("t7_echo0", echo_at(0), 32'h10);
    check("t7_echo1", echo_at(1), 32'h20);
    check("t7_echo2", echo_at(2), 32'h30);

    // 6: reset mid ADD packet, then echo 0xEC
    clear_obs();
    tx_q = {8'hA0, 8'h00, 8'h08, 8'h00, 8'h01};
    send_q();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("t6_word_valid", {31'd0, word_valid_o}, 32'd0);
    check("t6_rx_ready", {31'd0, rx_ready_o}, 32'd1);
    tx_q = {8'hEC, 8'h00, 8'h01, 8'h00, 8'hEC};
    send_q();
    idle(3);
    check("t6_echo_cnt", echo_q.size(), 32'd1);
    check("t6_echo0", echo_at(0), 32'hEC);
    check("t6_no_word", word_q.size(), 32'd0);
    check("t6_err", err_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
